ob_cn_table_aged: RTL and testbench

OB_CN_TABLE_AGED -- requirements
Module: ob_cn_table_aged

---
 rtl/bcd_pkg.sv | 7 +
 rtl/ob_pkg.sv | 23 ++
 rtl/ob_cn_table_aged_if.sv | 35 +++
 rtl/ob_cn_table_entry.sv | 56 +++++
 rtl/ob_cn_table_aged.sv | 167 ++++++++++++++++
 tb/tb_ob_cn_table_aged.sv | 272 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/bcd_pkg.sv
// Packed-BCD price type shared across the order-book blocks.
package bcd_pkg;

  // Four BCD digits. Digit-wise ordering matches unsigned binary ordering for valid BCD.
  typedef logic [15:0] price_t;

endpackage

// File: rtl/ob_pkg.sv
// Order-book command types, uid type and conditional-table arbitration encodings.
package ob_pkg;

  typedef logic [7:0] uid_t;

  typedef enum logic {SideBuy = 1'b0, SideSell = 1'b1} side_e;

  typedef struct packed {
    uid_t            uid;
    side_e           side;
    bcd_pkg::price_t trig;
    logic [15:0]     qty;
  } cmd_t;

  localparam int unsigned ArbRoundRobin = 0;
  localparam int unsigned ArbOldest     = 1;

  // Buy stops fire once the traded ask reaches the trigger; sell stops once the bid falls to it.
  function automatic logic cn_matured(cmd_t c, bcd_pkg::price_t ask, bcd_pkg::price_t bid);
    return (c.side == SideBuy) ? (ask >= c.trig) : (bid <= c.trig);
  endfunction

endpackage

// File: rtl/ob_cn_table_aged_if.sv
// Command, event, cancel and matured-output bundle of the conditional-order table.
interface ob_cn_table_aged_if #(
  parameter int unsigned N = 8
);
  import ob_pkg::*;

  logic                   cmd_vld;
  cmd_t                   cmd_r;
  logic                   cmd_rdy;
  logic                   cntrl_evt_texe_r;
  bcd_pkg::price_t        cntrl_evt_texe_ask_r;
  bcd_pkg::price_t        cntrl_evt_texe_bid_r;
  logic                   cancel;
  uid_t                   cancel_uid;
  logic                   cancel_hit_w;
  logic                   flush;
  logic                   mtr_vld_r;
  cmd_t                   mtr_r;
  logic                   mtr_accept;
  logic                   full_r;
  logic [$clog2(N+1)-1:0] occupancy_r;

  modport master (
    output cmd_vld, cmd_r, cntrl_evt_texe_r, cntrl_evt_texe_ask_r, cntrl_evt_texe_bid_r,
    output cancel, cancel_uid, flush, mtr_accept,
    input  cmd_rdy, cancel_hit_w, mtr_vld_r, mtr_r, full_r, occupancy_r
  );

  modport slave (
    input  cmd_vld, cmd_r, cntrl_evt_texe_r, cntrl_evt_texe_ask_r, cntrl_evt_texe_bid_r,
    input  cancel, cancel_uid, flush, mtr_accept,
    output cmd_rdy, cancel_hit_w, mtr_vld_r, mtr_r, full_r, occupancy_r
  );

endinterface

// File: rtl/ob_cn_table_entry.sv
// One resident conditional command: holds payload, busy flag and sticky maturity flag.
module ob_cn_table_entry
  import ob_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            alloc_i,
  input  logic            dealloc_i,
  input  cmd_t            cmd_i,
  input  logic            texe_i,
  input  bcd_pkg::price_t ask_i,
  input  bcd_pkg::price_t bid_i,
  output logic            busy_o,
  output logic            matured_o,
  output cmd_t            cmd_o
);

  logic busy_q, busy_d;
  logic matured_q, matured_d;
  cmd_t cmd_q;

  // Alloc never targets a busy entry, so alloc and dealloc are exclusive here.
  always_comb begin
    busy_d    = busy_q;
    matured_d = matured_q;
    if (flush_i || dealloc_i) begin
      busy_d    = 1'b0;
      matured_d = 1'b0;
    end else if (alloc_i) begin
      busy_d    = 1'b1;
      matured_d = 1'b0;
    end else if (busy_q && texe_i && cn_matured(cmd_q, ask_i, bid_i)) begin
      matured_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      matured_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      matured_q <= matured_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_i) cmd_q <= cmd_i;
  end

  assign busy_o    = busy_q;
  assign matured_o = matured_q;
  assign cmd_o     = cmd_q;

endmodule

// File: rtl/ob_cn_table_aged.sv
// Conditional-order table: N resident entries, age-matrix or round-robin pick of matured
// entries into a single-slot output latch, with cancel-by-uid and flush.
module ob_cn_table_aged
  import ob_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned ARB_MODE = ArbOldest
) (
  input logic               clk,
  input logic               rst,
  ob_cn_table_aged_if.slave bus
);

  localparam int unsigned OccW = $clog2(N + 1);
  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    entry_busy_r, entry_mat;
  cmd_t            entry_cmd [N];
  logic [N-1:0]    alloc, sel, sel_old, sel_rr, cancel_match, dealloc, busy_nxt;
  logic [N-1:0]    age_q [N];
  logic [N-1:0]    age_d [N];
  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic [OccW-1:0] occ_q, occ_d;
  logic            full_q;
  logic            mtr_vld_q, mtr_vld_d;
  cmd_t            mtr_q, sel_cmd;
  logic            accept, load, alloc_hit, rr_hit;

  assign accept = bus.cmd_vld & ~full_q & ~bus.flush;
  assign load   = (|entry_mat) & (~mtr_vld_q | bus.mtr_accept) & ~bus.flush;

  // Allocation looks only at the registered busy vector, so a slot freed this cycle waits one.
  always_comb begin
    alloc     = '0;
    alloc_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (accept && !alloc_hit && !entry_busy_r[i]) begin
        alloc[i]  = 1'b1;
        alloc_hit = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_entry
    ob_cn_table_entry u_entry (
      .clk       (clk),
      .rst       (rst),
      .flush_i   (bus.flush),
      .alloc_i   (alloc[g]),
      .dealloc_i (dealloc[g]),
      .cmd_i     (bus.cmd_r),
      .texe_i    (bus.cntrl_evt_texe_r),
      .ask_i     (bus.cntrl_evt_texe_ask_r),
      .bid_i     (bus.cntrl_evt_texe_bid_r),
      .busy_o    (entry_busy_r[g]),
      .matured_o (entry_mat[g]),
      .cmd_o     (entry_cmd[g])
    );
  end

  // age_q[i][j] set means i was allocated after j; oldest matured has no older matured peer.
  always_comb begin
    sel_old = '0;
    for (int i = 0; i < N; i++) begin
      sel_old[i] = entry_mat[i] & ~(|(age_q[i] & entry_mat));
    end
  end

  // First pass searches from the pointer upward, second pass wraps to the bottom.
  always_comb begin
    sel_rr = '0;
    rr_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!rr_hit && entry_mat[i] && (i >= int'(rr_ptr_q))) begin
        sel_rr[i] = 1'b1;
        rr_hit    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!rr_hit && entry_mat[i]) begin
        sel_rr[i] = 1'b1;
        rr_hit    = 1'b1;
      end
    end
  end

  assign sel = (ARB_MODE == ArbRoundRobin) ? sel_rr : sel_old;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    sel_cmd  = '0;
    for (int i = 0; i < N; i++) begin
      if (sel[i]) begin
        sel_cmd = entry_cmd[i];
        if (load) rr_ptr_d = (i == N - 1) ? '0 : PtrW'(i + 1);
      end
    end
  end

  // The transfer wins over a cancel aimed at the same entry.
  always_comb begin
    cancel_match = '0;
    for (int i = 0; i < N; i++) begin
      cancel_match[i] = bus.cancel & ~bus.flush & entry_busy_r[i] &
                        (entry_cmd[i].uid == bus.cancel_uid) & ~(load & sel[i]);
    end
  end

  assign dealloc  = cancel_match | (sel & {N{load}});
  assign busy_nxt = bus.flush ? '0 : ((entry_busy_r & ~dealloc) | alloc);

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < N; i++) begin
      occ_d = occ_d + OccW'(busy_nxt[i]);
    end
  end

  always_comb begin
    age_d = age_q;
    if (bus.flush) begin
      age_d = '{default: '0};
    end else begin
      for (int i = 0; i < N; i++) begin
        if (alloc[i]) begin
          for (int j = 0; j < N; j++) age_d[j][i] = 1'b0;
          for (int j = 0; j < N; j++) age_d[i][j] = (i != j);
        end
      end
    end
  end

  always_comb begin
    mtr_vld_d = mtr_vld_q;
    if (bus.flush)           mtr_vld_d = 1'b0;
    else if (load)           mtr_vld_d = 1'b1;
    else if (bus.mtr_accept) mtr_vld_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q     <= '{default: '0};
      rr_ptr_q  <= '0;
      occ_q     <= '0;
      full_q    <= 1'b0;
      mtr_vld_q <= 1'b0;
    end else begin
      age_q     <= age_d;
      rr_ptr_q  <= rr_ptr_d;
      occ_q     <= occ_d;
      full_q    <= &busy_nxt;
      mtr_vld_q <= mtr_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) mtr_q <= sel_cmd;
  end

  assign bus.cmd_rdy      = ~full_q;
  assign bus.cancel_hit_w = |cancel_match;
  assign bus.mtr_vld_r    = mtr_vld_q;
  assign bus.mtr_r        = mtr_q;
  assign bus.full_r       = full_q;
  assign bus.occupancy_r  = occ_q;

endmodule

// File: tb/tb_ob_cn_table_aged.sv
// Directed bench: oldest-first table for most scenarios, a round-robin twin for arbitration order.
module tb_ob_cn_table_aged;
  import ob_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  ob_cn_table_aged_if #(.N(4)) bus ();
  ob_cn_table_aged_if #(.N(4)) bus_rr ();

  ob_cn_table_aged #(.N(4), .ARB_MODE(ArbOldest)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ob_cn_table_aged #(.N(4), .ARB_MODE(ArbRoundRobin)) dut_rr (
    .clk (clk),
    .rst (rst),
    .bus (bus_rr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t mk(input logic [7:0] uid, input side_e side, input logic [15:0] trig);
    cmd_t c;
    c.uid  = uid;
    c.side = side;
    c.trig = trig;
    c.qty  = {8'h00, uid};
    return c;
  endfunction

  task automatic push(input cmd_t c);
    bus.cmd_vld = 1'b1;
    bus.cmd_r   = c;
    step();
    bus.cmd_vld = 1'b0;
  endtask

  task automatic push_rr(input cmd_t c);
    bus_rr.cmd_vld = 1'b1;
    bus_rr.cmd_r   = c;
    step();
    bus_rr.cmd_vld = 1'b0;
  endtask

  task automatic texe(input logic [15:0] ask, input logic [15:0] bid);
    bus.cntrl_evt_texe_r     = 1'b1;
    bus.cntrl_evt_texe_ask_r = ask;
    bus.cntrl_evt_texe_bid_r = bid;
    step();
    bus.cntrl_evt_texe_r = 1'b0;
  endtask

  task automatic texe_rr(input logic [15:0] ask);
    bus_rr.cntrl_evt_texe_r     = 1'b1;
    bus_rr.cntrl_evt_texe_ask_r = ask;
    bus_rr.cntrl_evt_texe_bid_r = 16'h9999;
    step();
    bus_rr.cntrl_evt_texe_r = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.cmd_vld = 1'b0;  bus.cmd_r = '0;  bus.cntrl_evt_texe_r = 1'b0;
    bus.cntrl_evt_texe_ask_r = '0;  bus.cntrl_evt_texe_bid_r = 16'h9999;
    bus.cancel = 1'b0;  bus.cancel_uid = '0;  bus.flush = 1'b0;  bus.mtr_accept = 1'b0;
    bus_rr.cmd_vld = 1'b0;  bus_rr.cmd_r = '0;  bus_rr.cntrl_evt_texe_r = 1'b0;
    bus_rr.cntrl_evt_texe_ask_r = '0;  bus_rr.cntrl_evt_texe_bid_r = 16'h9999;
    bus_rr.cancel = 1'b0;  bus_rr.cancel_uid = '0;  bus_rr.flush = 1'b0;
    bus_rr.mtr_accept = 1'b0;
    step();
    step();
    rst = 1'b0;

    check("rst_mtr_vld", 64'(bus.mtr_vld_r), 64'd0);
    check("rst_full", 64'(bus.full_r), 64'd0);
    check("rst_occ", 64'(bus.occupancy_r), 64'd0);
    check("rst_rdy", 64'(bus.cmd_rdy), 64'd1);

    // Fill A..D; a single event later matures B (sell) and D (buy).
    push(mk(8'h11, SideSell, 16'h0100));
    push(mk(8'h12, SideSell, 16'h0500));
    push(mk(8'h13, SideBuy, 16'h0900));
    push(mk(8'h14, SideBuy, 16'h0300));
    check("fill_occ", 64'(bus.occupancy_r), 64'd4);
    check("fill_full", 64'(bus.full_r), 64'd1);

    bus.cmd_vld = 1'b1;
    bus.cmd_r   = mk(8'h20, SideSell, 16'h0000);
    #1;
    check("full_rdy", 64'(bus.cmd_rdy), 64'd0);
    texe(16'h0400, 16'h0450);
    check("full_ignored_occ", 64'(bus.occupancy_r), 64'd4);
    check("pre_load_vld", 64'(bus.mtr_vld_r), 64'd0);
    step();
    check("oldest_first_vld", 64'(bus.mtr_vld_r), 64'd1);
    check("oldest_first_uid", 64'(bus.mtr_r.uid), 64'h12);
    check("xfer_full_drop", 64'(bus.full_r), 64'd0);
    check("xfer_occ", 64'(bus.occupancy_r), 64'd3);
    step();
    bus.cmd_vld = 1'b0;
    check("reuse_occ", 64'(bus.occupancy_r), 64'd4);
    check("reuse_full", 64'(bus.full_r), 64'd1);

    bus.mtr_accept = 1'b1;
    step();
    check("second_uid", 64'(bus.mtr_r.uid), 64'h14);
    check("second_occ", 64'(bus.occupancy_r), 64'd3);
    step();
    check("drain_vld", 64'(bus.mtr_vld_r), 64'd0);
    bus.mtr_accept = 1'b0;

    // Cancel racing the transfer of the same entry, then plain cancels.
    push(mk(8'h15, SideBuy, 16'h0200));
    texe(16'h0250, 16'h9999);
    bus.cancel     = 1'b1;
    bus.cancel_uid = 8'h15;
    #1;
    check("cancel_vs_xfer_hit", 64'(bus.cancel_hit_w), 64'd0);
    step();
    check("cancel_vs_xfer_uid", 64'(bus.mtr_r.uid), 64'h15);
    check("cancel_vs_xfer_occ", 64'(bus.occupancy_r), 64'd3);
    bus.cancel_uid = 8'h13;
    #1;
    check("cancel_busy_hit", 64'(bus.cancel_hit_w), 64'd1);
    step();
    check("cancel_busy_occ", 64'(bus.occupancy_r), 64'd2);
    bus.cancel_uid = 8'h15;
    #1;
    check("cancel_latched_hit", 64'(bus.cancel_hit_w), 64'd0);
    step();
    bus.cancel = 1'b0;
    check("cancel_latched_vld", 64'(bus.mtr_vld_r), 64'd1);
    check("cancel_latched_uid", 64'(bus.mtr_r.uid), 64'h15);

    // Flush with three entries, a pending output, a concurrent command and cancel.
    push(mk(8'h30, SideSell, 16'h0000));
    check("pre_flush_occ", 64'(bus.occupancy_r), 64'd3);
    bus.flush      = 1'b1;
    bus.cmd_vld    = 1'b1;
    bus.cmd_r      = mk(8'h31, SideBuy, 16'h0100);
    bus.cancel     = 1'b1;
    bus.cancel_uid = 8'h11;
    #1;
    check("flush_cancel_hit", 64'(bus.cancel_hit_w), 64'd0);
    step();
    bus.flush   = 1'b0;
    bus.cmd_vld = 1'b0;
    bus.cancel  = 1'b0;
    check("flush_occ", 64'(bus.occupancy_r), 64'd0);
    check("flush_vld", 64'(bus.mtr_vld_r), 64'd0);
    check("flush_full", 64'(bus.full_r), 64'd0);
    step();
    check("flush_cmd_dropped", 64'(bus.occupancy_r), 64'd0);

    // Output stalled with two more matured entries waiting behind it.
    push(mk(8'h40, SideBuy, 16'h0100));
    push(mk(8'h41, SideBuy, 16'h0100));
    push(mk(8'h42, SideBuy, 16'h0100));
    texe(16'h0200, 16'h9999);
    step();
    check("stall_first_uid", 64'(bus.mtr_r.uid), 64'h40);
    for (int k = 0; k < 10; k++) begin
      step();
      check("stall_hold_uid", 64'(bus.mtr_r.uid), 64'h40);
      check("stall_hold_vld", 64'(bus.mtr_vld_r), 64'd1);
    end
    check("stall_occ", 64'(bus.occupancy_r), 64'd2);
    bus.mtr_accept = 1'b1;
    step();
    check("b2b_uid1", 64'(bus.mtr_r.uid), 64'h41);
    check("b2b_occ1", 64'(bus.occupancy_r), 64'd1);
    step();
    check("b2b_uid2", 64'(bus.mtr_r.uid), 64'h42);
    check("b2b_occ2", 64'(bus.occupancy_r), 64'd0);
    step();
    check("b2b_empty_vld", 64'(bus.mtr_vld_r), 64'd0);
    bus.mtr_accept = 1'b0;

    // Reset while a matured command sits in the output latch.
    push(mk(8'h50, SideBuy, 16'h0100));
    texe(16'h0200, 16'h9999);
    step();
    check("pre_rst_vld", 64'(bus.mtr_vld_r), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_vld", 64'(bus.mtr_vld_r), 64'd0);
    check("mid_rst_occ", 64'(bus.occupancy_r), 64'd0);
    step();
    step();
    step();
    check("post_rst_vld", 64'(bus.mtr_vld_r), 64'd0);

    // Reused low slot holds the younger entry; oldest-first must pick slot 1.
    push(mk(8'h80, SideBuy, 16'h0100));
    push(mk(8'h81, SideBuy, 16'h0900));
    bus.cancel     = 1'b1;
    bus.cancel_uid = 8'h80;
    #1;
    check("age_cancel_hit", 64'(bus.cancel_hit_w), 64'd1);
    step();
    bus.cancel = 1'b0;
    push(mk(8'h82, SideBuy, 16'h0100));
    texe(16'h0950, 16'h9999);
    step();
    check("age_oldest_uid", 64'(bus.mtr_r.uid), 64'h81);
    bus.mtr_accept = 1'b1;
    step();
    check("age_younger_uid", 64'(bus.mtr_r.uid), 64'h82);
    step();
    check("age_drain_vld", 64'(bus.mtr_vld_r), 64'd0);
    check("age_drain_occ", 64'(bus.occupancy_r), 64'd0);
    bus.mtr_accept = 1'b0;

    // Round-robin: four matured together drain 0..3 on consecutive cycles.
    bus_rr.mtr_accept = 1'b1;
    for (int k = 0; k < 4; k++) push_rr(mk(8'(8'h60 + k), SideBuy, 16'h0100));
    texe_rr(16'h0200);
    for (int k = 0; k < 4; k++) begin
      step();
      check("rr_batch_vld", 64'(bus_rr.mtr_vld_r), 64'd1);
      check("rr_batch_uid", 64'(bus_rr.mtr_r.uid), 64'(8'h60 + k));
    end
    step();
    check("rr_batch_empty_vld", 64'(bus_rr.mtr_vld_r), 64'd0);
    check("rr_batch_empty_occ", 64'(bus_rr.occupancy_r), 64'd0);

    // Pointer left at 2 after slot 1 transfers: slot 2 beats the older slot 0.
    push_rr(mk(8'h70, SideBuy, 16'h0900));
    push_rr(mk(8'h71, SideBuy, 16'h0100));
    push_rr(mk(8'h72, SideBuy, 16'h0900));
    texe_rr(16'h0200);
    step();
    check("rr_single_uid", 64'(bus_rr.mtr_r.uid), 64'h71);
    step();
    check("rr_single_empty", 64'(bus_rr.mtr_vld_r), 64'd0);
    texe_rr(16'h0950);
    step();
    check("rr_ptr_uid", 64'(bus_rr.mtr_r.uid), 64'h72);
    step();
    check("rr_wrap_uid", 64'(bus_rr.mtr_r.uid), 64'h70);
    step();
    check("rr_final_vld", 64'(bus_rr.mtr_vld_r), 64'd0);
    bus_rr.mtr_accept = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
